uart_rx_gen: RTL
================

// Module: uart_rx_gen
// PURPOSE
// - Parametrised UART receiver; next generation of the fixed 8-bit, fixed-parity receiver.
// - Adds the following over that receiver:
//   - configurable data width and stop-bit count;
//   - runtime parity mode (none/even/odd);
//   - 16x oversampling with a 3-sample majority vote and false-start rejection;
//   - framing, parity, break and overrun flags;
//   - a valid/ready output handshake.
// - Sits between the pad-side rx pin and the command/FIFO logic in the top-level UART.
// PARAMETERS
// - DW         8         data bits per frame, legal 5..9
// - CLK_HZ     50000000  system clock frequency in Hz
// - BAUD       115200    line rate in bit/s
// - OVS        16        oversampling ticks per bit, legal 8 or 16
// - STOP_BITS  1         stop bits checked, legal 1 or 2
// - DIV        CLK_HZ/(BAUD*OVS)  clocks per tick, integer-truncated (=27 at defaults)
// PORTS
// - clk         in   1      system clock, all logic on rising edge
// - rst         in   1      synchronous reset, active-high
// - rx          in   1      asynchronous serial input, idle high
// - cfg_parity  in   2      0=none, 1=even, 2=odd, 3=treated as none; sampled only in IDLE
// - rx_data     out  DW     received word, LSB first on the line
// - rx_valid    out  1      rx_data and flags are valid
// - rx_ready    in   1      consumer accepts the word when rx_valid && rx_ready
// - par_err     out  1      parity mismatch for the held word
// - frm_err     out  1      a stop bit was sampled 0 for the held word
// - brk         out  1      held word all-zero, parity (if enabled) 0 and stop 0
// - overrun     out  1      at least one frame dropped while the word was held
// BEHAVIOUR
// - Reset: every output is 0; state is IDLE; counters are 0; both synchroniser flops are 1.
// - rx passes through a 2-flop synchroniser; everything below uses the synchronised rx_s.
// - Tick generator: pulses tick once every DIV clocks.
//   - Free-running while state != IDLE.
//   - Held at 0 in IDLE.
// - Sampling: each bit is decided by majority of rx_s at ticks OVS/2-1, OVS/2 and OVS/2+1
//   within the bit.
// - FSM:
//   - IDLE -> START: on a 1->0 edge of rx_s; latch cfg_parity; clear tick and bit counters.
//   - START: if the majority vote is 1 (glitch), go to IDLE with no output. Otherwise go to DATA.
//   - DATA: shift in DW bits, LSB first, one per OVS ticks.
//     Then go to PAR if parity is enabled, else to STOP.
//   - PAR: sample the parity bit.
//     - Even mode: par_err = ^{data,p}.
//     - Odd mode: par_err = ~^{data,p}.
//   - STOP: sample STOP_BITS bits; any 0 sets frm_err.
//     After the last stop sample, go to IDLE. The next falling edge may start a frame at once.
// - Output handshake:
//   - Frame completion is the cycle after the last stop sample.
//   - On completion with rx_valid=0: load rx_data and the flags, and set rx_valid=1.
//   - On completion with rx_valid=1 and rx_ready=0: drop the new frame; set overrun=1;
//     keep rx_data and the other flags.
//   - On completion in the same cycle as a handshake (rx_valid && rx_ready): the old word is
//     consumed, the new word is loaded, rx_valid stays 1 and overrun=0.
//   - Handshake with no completion: clear rx_valid, par_err, frm_err, brk and overrun next cycle.
//   - rx_data and the flags are stable while rx_valid=1 and the word is not consumed.
// - Latency: from the mid-point of the last stop bit to rx_valid is at most OVS/2+3 ticks plus 2 clocks.
// - Reset during a frame: next cycle returns to IDLE and clears outputs; the partial frame is discarded.
// - cfg_parity changes during a frame have no effect until the next IDLE.
// STRUCTURE
// - Shared package pkg_uart_gen:
//   - parity_mode_t enum {PAR_NONE, PAR_EVEN, PAR_ODD};
//   - state_rxg_t enum {IDLE, START, DATA, PAR, STOP};
//   - function calc_div(clk_hz, baud, ovs);
//   - count_t sized $clog2(OVS).
// - Sub-module uart_baud_tick:
//   - parameter DIV; ports clk, rst, en, tick;
//   - counter restarts at 0 when en is low.
// - Top holds the synchroniser, vote, FSM, shift register and output register.
// TESTING (DW=8, OVS=16, DIV=27, so 432 clocks/bit, STOP_BITS=1 unless stated)
// - Parity none, send 0xA5, rx_ready=1 -> one-cycle rx_valid, rx_data=0xA5, all flags 0.
// - Even parity, send 0x37 with parity bit 0 (correct bit is 1) -> rx_data=0x37, par_err=1;
//   repeat with bit 1 -> par_err=0.
// - Send 0x3C with stop bit 0 -> frm_err=1.
//   Send 0x00 with stop 0, parity none -> brk=1 and frm_err=1.
// - Pulse rx low for 100 clocks (less than half a bit) -> no rx_valid; FSM back in IDLE
//   within 2 bit times.
// - rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data=0x11, overrun=1;
//   raise rx_ready -> rx_valid and overrun clear next cycle.
// - Assert rst for 1 cycle mid-way through bit 3 of 0xFF -> outputs 0 next cycle;
//   a following 0x5A frame is received correctly.
//   Also run STOP_BITS=2 with the second stop bit 0 -> frm_err=1.

Source files
------------

// File: rtl/uart_rx_gen_pkg.sv
// Shared types and helpers for the generic UART receiver family.
package pkg_uart_gen;

    localparam int OVS_MAX = 16;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_rxg_t;

    // Sized for the largest legal oversampling ratio; smaller ratios wrap early.
    typedef logic [$clog2(OVS_MAX)-1:0] count_t;

    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        return clk_hz / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_gen_baud_tick.sv
// Oversampling tick generator: one-clock pulse every DIV clocks while enabled.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_gen.sv
// Oversampling UART receiver with majority vote, runtime parity, error flags
// and a valid/ready output register.
module uart_rx_gen
    import pkg_uart_gen::*;
#(
    parameter int DW        = 8,
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int OVS       = 16,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    input  logic [1:0]    cfg_parity,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          par_err,
    output logic          frm_err,
    output logic          brk,
    output logic          overrun
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
    localparam int BW  = $clog2(DW + 1);
    localparam count_t T_LO   = count_t'(OVS / 2 - 1);
    localparam count_t T_MID  = count_t'(OVS / 2);
    localparam count_t T_HI   = count_t'(OVS / 2 + 1);
    localparam count_t T_LAST = count_t'(OVS - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DW - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic tick, vote_tick, maj, rx_fall;

    state_rxg_t   state_q, state_d;
    count_t       tcnt_q, tcnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [1:0]   votes_q, votes_d;
    logic [DW-1:0] shift_q, shift_d;
    parity_mode_t par_mode_q, par_mode_d;
    logic par_bit_q, par_bit_d, perr_q, perr_d, ferr_q, ferr_d;
    logic stop_one_q, stop_one_d, done_q, done_d;

    logic [DW-1:0] data_q, data_d;
    logic valid_q, valid_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic brk_q, brk_d, ovr_q, ovr_d, consume, brk_frame;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    assign rx_fall   = rx_prev_q & ~rx_s_q;
    assign vote_tick = tick && (tcnt_q == T_HI);
    assign maj       = (votes_q[0] & votes_q[1]) | (votes_q[0] & rx_s_q) | (votes_q[1] & rx_s_q);

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bit_cnt_d  = bit_cnt_q;
        votes_d    = votes_q;
        shift_d    = shift_q;
        par_mode_d = par_mode_q;
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop_one_d = stop_one_q;
        done_d     = 1'b0;
        if (tick) begin
            tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + 1'b1;
            if (tcnt_q == T_LO)  votes_d[0] = rx_s_q;
            if (tcnt_q == T_MID) votes_d[1] = rx_s_q;
        end
        unique case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d    = START;
                    tcnt_d     = '0;
                    bit_cnt_d  = '0;
                    par_bit_d  = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    stop_one_d = 1'b0;
                    case (cfg_parity)
                        2'd1:    par_mode_d = PAR_EVEN;
                        2'd2:    par_mode_d = PAR_ODD;
                        default: par_mode_d = PAR_NONE;
                    endcase
                end
            end
            START: begin
                // A start bit that votes high was a glitch: abandon silently.
                if (vote_tick) state_d = maj ? IDLE : DATA;
            end
            DATA: begin
                if (vote_tick) begin
                    shift_d = {maj, shift_q[DW-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (par_mode_q == PAR_NONE) ? STOP : PAR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (vote_tick) begin
                    par_bit_d = maj;
                    perr_d    = (par_mode_q == PAR_EVEN) ? ^{shift_q, maj} : ~^{shift_q, maj};
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (vote_tick) begin
                    if (!maj) ferr_d = 1'b1;
                    if (maj)  stop_one_d = 1'b1;
                    if (bit_cnt_q == LAST_STOP) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign brk_frame = (shift_q == '0) && !par_bit_q && !stop_one_q;
    assign consume   = valid_q && rx_ready;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        brk_d     = brk_q;
        ovr_d     = ovr_q;
        if (done_q) begin
            if (!valid_q || consume) begin
                data_d    = shift_q;
                valid_d   = 1'b1;
                par_err_d = perr_q;
                frm_err_d = ferr_q;
                brk_d     = brk_frame;
                ovr_d     = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (consume) begin
            valid_d   = 1'b0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
            brk_d     = 1'b0;
            ovr_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            tcnt_q     <= '0;
            bit_cnt_q  <= '0;
            votes_q    <= '0;
            shift_q    <= '0;
            par_mode_q <= PAR_NONE;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_one_q <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            bit_cnt_q  <= bit_cnt_d;
            votes_q    <= votes_d;
            shift_q    <= shift_d;
            par_mode_q <= par_mode_d;
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            stop_one_q <= stop_one_d;
            done_q     <= done_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign par_err  = par_err_q;
    assign frm_err  = frm_err_q;
    assign brk      = brk_q;
    assign overrun  = ovr_q;

endmodule
